// File: rtl/midi_note_event_rx.sv
// midi_note_event_rx: 8N1 MIDI receiver and Note-On/Note-Off parser emitting one-cycle note events.
// Handles running status, realtime bytes, channel filtering and framing errors.
module midi_note_event_rx #(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 31250
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       omni,
   input  logic [3:0] channel_sel,
   output logic       out_valid,
   output logic       on_off,
   output logic [7:0] note,
   output logic [3:0] volume,
   output logic [3:0] channel,
   output logic       frame_err
);
   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
   typedef enum logic [1:0] {WAIT_STATUS, WAIT_NOTE, WAIT_VEL} ps_t;

   logic [1:0]    sync_q;
   logic          rxs, rxs_prev_q;
   rx_state_t     rx_state_q, rx_state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          byte_stb, stop_err;
   ps_t           ps_q, ps_d;
   logic [7:0]    status_q, status_d;
   logic          rs_valid_q, rs_valid_d;
   logic [6:0]    note_lat_q, note_lat_d;
   logic          out_valid_q, out_valid_d, on_off_q, on_off_d, frame_err_q, frame_err_d;
   logic [6:0]    note_q, note_d;
   logic [3:0]    volume_q, volume_d, channel_q, channel_d;

   assign rxs = sync_q[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q      <= 2'b11;
         rxs_prev_q  <= 1'b1;
         rx_state_q  <= IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shreg_q     <= '0;
         ps_q        <= WAIT_STATUS;
         status_q    <= '0;
         rs_valid_q  <= 1'b0;
         note_lat_q  <= '0;
         out_valid_q <= 1'b0;
         on_off_q    <= 1'b0;
         note_q      <= '0;
         volume_q    <= '0;
         channel_q   <= '0;
         frame_err_q <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], rx};
         rxs_prev_q  <= rxs;
         rx_state_q  <= rx_state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shreg_q     <= shreg_d;
         ps_q        <= ps_d;
         status_q    <= status_d;
         rs_valid_q  <= rs_valid_d;
         note_lat_q  <= note_lat_d;
         out_valid_q <= out_valid_d;
         on_off_q    <= on_off_d;
         note_q      <= note_d;
         volume_q    <= volume_d;
         channel_q   <= channel_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      cnt_d      = cnt_q + CW'(1);
      bit_d      = bit_q;
      shreg_d    = shreg_q;
      byte_stb   = 1'b0;
      stop_err   = 1'b0;
      case (rx_state_q)
         IDLE: begin
            cnt_d = '0;
            if (rxs_prev_q && !rxs) rx_state_d = START;
         end
         START: if (cnt_q == HALF_M1) begin
            cnt_d      = '0;
            bit_d      = '0;
            rx_state_d = rxs ? IDLE : DATA;
         end
         DATA: if (cnt_q == FULL_M1) begin
            cnt_d   = '0;
            shreg_d = {rxs, shreg_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) rx_state_d = STOP;
         end
         default: if (cnt_q == FULL_M1) begin
            cnt_d      = '0;
            rx_state_d = IDLE;
            byte_stb   = rxs;
            stop_err   = !rxs;
         end
      endcase
   end

   always_comb begin
      ps_d        = ps_q;
      status_d    = status_q;
      rs_valid_d  = rs_valid_q;
      note_lat_d  = note_lat_q;
      out_valid_d = 1'b0;
      frame_err_d = stop_err;
      on_off_d    = on_off_q;
      note_d      = note_q;
      volume_d    = volume_q;
      channel_d   = channel_q;
      if (stop_err) begin
         ps_d       = WAIT_STATUS;
         rs_valid_d = 1'b0;
      end else if (byte_stb && shreg_q[7]) begin
         // Realtime bytes (0xF8-0xFF) leave the parser untouched
         if (!(&shreg_q[7:3])) begin
            rs_valid_d = shreg_q[7:5] == 3'b100;
            ps_d       = rs_valid_d ? WAIT_NOTE : WAIT_STATUS;
            if (rs_valid_d) status_d = shreg_q;
         end
      end else if (byte_stb) begin
         if (ps_q == WAIT_VEL) begin
            ps_d = WAIT_NOTE;
            if (omni || status_q[3:0] == channel_sel) begin
               out_valid_d = 1'b1;
               on_off_d    = status_q[4] && |shreg_q[6:0];
               note_d      = note_lat_q;
               volume_d    = shreg_q[6:3];
               channel_d   = status_q[3:0];
            end
         end else if (ps_q == WAIT_NOTE || rs_valid_q) begin
            note_lat_d = shreg_q[6:0];
            ps_d       = WAIT_VEL;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign on_off    = on_off_q;
   assign note      = {1'b0, note_q};
   assign volume    = volume_q;
   assign channel   = channel_q;
   assign frame_err = frame_err_q;
endmodule

// File: tb/tb_midi_note_event_rx.sv
// tb_midi_note_event_rx: directed bench for the MIDI note receiver at 32 clocks per bit.
module tb_midi_note_event_rx;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic       omni = 1'b1;
   logic [3:0] channel_sel = 4'd0;
   logic       out_valid, on_off, frame_err;
   logic [7:0] note;
   logic [3:0] volume, channel;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int ev_cyc = 0;
   int last_start = 0;
   int fe_cnt = 0;
   int n0, f0;
   logic [16:0] evq[$];

   midi_note_event_rx #(.CLK_HZ(1_000_000), .BAUD(31250)) dut (
      .clk(clk), .reset(reset), .rx(rx), .omni(omni), .channel_sel(channel_sel),
      .out_valid(out_valid), .on_off(on_off), .note(note), .volume(volume),
      .channel(channel), .frame_err(frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Event log sampled mid-cycle; packed as {on_off, note, volume, channel}
   always @(negedge clk) begin
      if (out_valid) begin
         evq.push_back({on_off, note, volume, channel});
         ev_cyc <= cyc;
      end
      if (frame_err) fe_cnt <= fe_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [16:0] get_ev(input int i);
      return (evq.size() > i) ? evq[i] : 17'h1FFFF;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
      rx = 1'b0;
      last_start = cyc;
      idle(32);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         idle(32);
      end
      rx = stop;
      idle(32);
      rx = 1'b1;
   endtask

   task automatic chk_outs_zero(input string tag);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_onoff"}, on_off, 0);
      chk({tag, "_note"}, note, 0);
      chk({tag, "_vol"}, volume, 0);
      chk({tag, "_ch"}, channel, 0);
      chk({tag, "_ferr"}, frame_err, 0);
   endtask

   initial begin
      idle(3);
      reset = 1'b0;
      idle(2);
      chk_outs_zero("rst");

      n0 = evq.size();
      send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
      idle(10);
      chk("on_cnt", evq.size() - n0, 1);
      chk("on_ev", get_ev(n0), {1'b1, 8'h3C, 4'hC, 4'h0});
      chk("on_lat", ev_cyc - last_start, 307);
      chk("on_hold_note", note, 8'h3C);
      chk("on_hold_valid", out_valid, 0);

      n0 = evq.size();
      send_byte(8'h91); send_byte(8'h40); send_byte(8'h7F);
      send_byte(8'h40); send_byte(8'h00);
      idle(10);
      chk("rs_cnt", evq.size() - n0, 2);
      chk("rs_ev0", get_ev(n0), {1'b1, 8'h40, 4'hF, 4'h1});
      chk("rs_ev1", get_ev(n0 + 1), {1'b0, 8'h40, 4'h0, 4'h1});

      n0 = evq.size();
      send_byte(8'h85); send_byte(8'h45); send_byte(8'hF8); send_byte(8'h20);
      idle(10);
      chk("off_cnt", evq.size() - n0, 1);
      chk("off_ev", get_ev(n0), {1'b0, 8'h45, 4'h4, 4'h5});

      n0 = evq.size();
      omni = 1'b0;
      channel_sel = 4'd2;
      send_byte(8'h93); send_byte(8'h30); send_byte(8'h40);
      send_byte(8'h92); send_byte(8'h30); send_byte(8'h40);
      idle(10);
      chk("filt_cnt", evq.size() - n0, 1);
      chk("filt_ev", get_ev(n0), {1'b1, 8'h30, 4'h8, 4'h2});
      omni = 1'b1;

      n0 = evq.size();
      f0 = fe_cnt;
      send_byte(8'h90);
      send_byte(8'h3C, 1'b0);
      idle(64);
      send_byte(8'h50); send_byte(8'h10);
      idle(10);
      chk("ferr_cnt", fe_cnt - f0, 1);
      chk("ferr_noev", evq.size() - n0, 0);

      n0 = evq.size();
      f0 = fe_cnt;
      rx = 1'b0;
      idle(5);
      rx = 1'b1;
      idle(100);
      chk("glitch_noev", evq.size() - n0, 0);
      chk("glitch_noferr", fe_cnt - f0, 0);

      n0 = evq.size();
      send_byte(8'h90); send_byte(8'h3C);
      rx = 1'b0;
      idle(32 * 4);
      reset = 1'b1;
      rx = 1'b1;
      idle(3);
      reset = 1'b0;
      idle(400);
      chk("mrst_noev", evq.size() - n0, 0);
      chk_outs_zero("mrst");

      n0 = evq.size();
      send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
      idle(10);
      chk("resend_cnt", evq.size() - n0, 1);
      chk("resend_ev", get_ev(n0), {1'b1, 8'h3C, 4'hC, 4'h0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/midi_note_event_rx.md
Name: midi_note_event_rx

Overview:
- Front end of the synth voice path. Receives a serial MIDI stream on one pin at 31250 baud, 8N1.
- Parses Note-On and Note-Off messages, including running status.
- Emits one-cycle note events (out_valid, on_off, note, volume) that drive the triangle and sawtooth track allocators directly.
- Also reports framing errors and tracks message-parser state, so corrupted input cannot produce bogus notes.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- BAUD, 31250, serial bit rate.
- CLKS_PER_BIT, CLK_HZ/BAUD (derived localparam; 3200 at defaults). Must be >= 8.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial MIDI in; idle high; asynchronous to clk.
- omni  input  1  1 = accept all channels; 0 = accept only channel_sel.
- channel_sel  input  4  MIDI channel filter, used when omni=0.
- out_valid  output  1  one-cycle strobe marking a new note event.
- on_off  output  1  1 = note on, 0 = note off; valid with out_valid.
- note  output  8  note number, 0x00-0x7F (bit 7 always 0).
- volume  output  4  velocity[6:3].
- channel  output  4  channel of the event.
- frame_err  output  1  one-cycle strobe when a stop bit is sampled low.

Behaviour:
- Reset: every output is 0; parser returns to WAIT_STATUS; running status cleared; receiver returns to IDLE. Reset mid-byte or mid-message discards the partial data; no event is emitted.
- Sync: rx passes through a 2-flop synchronizer that resets to 1. All logic uses the synchronized value, rxs.
- Receiver FSM:
  - IDLE to START on a falling edge of rxs.
  - START: wait CLKS_PER_BIT/2 clocks, then sample. If rxs=1 (glitch), return to IDLE. Otherwise go to DATA.
  - DATA: sample 8 bits, LSB first, at CLKS_PER_BIT intervals. Bit counter runs 0..7.
  - STOP: sample one bit CLKS_PER_BIT later.
    - Stop bit = 1: assert the internal byte strobe for one cycle with the byte.
    - Stop bit = 0: pulse frame_err, give no byte strobe, reset the parser to WAIT_STATUS and clear running status.
  - After STOP, go to IDLE; the next falling edge is detected immediately.
- Parser, acting on each byte strobe:
  - 0xF8-0xFF (realtime): ignored entirely. Parser state and running status are unchanged, so a realtime byte may sit between note and velocity.
  - 0x80-0x9F: store the byte as running status and go to WAIT_NOTE. This also aborts any partial message.
  - 0xA0-0xF7: clear running status and go to WAIT_STATUS.
  - Data byte (bit 7 = 0):
    - In WAIT_STATUS with running status valid: the byte is the note; go to WAIT_VEL.
    - In WAIT_STATUS with no running status: ignored.
    - In WAIT_NOTE: latch the note; go to WAIT_VEL.
    - In WAIT_VEL: complete the message; go to WAIT_NOTE, keeping running status.
- Event on message completion:
  - on_off = (status[7:4]==9) && (velocity!=0). Note-On with velocity 0 is a note off.
  - volume = velocity[6:3]; channel = status[3:0].
  - Filter: if omni=0 and status[3:0]!=channel_sel, no event is emitted, but the parser still advances.
- Latency: out_valid rises the clock after the velocity byte's stop-bit sample cycle. It stays high for exactly 1 cycle.
- Output hold: note, on_off, volume and channel update only when out_valid fires and hold until the next event.
- Throughput: at most one event per 3 byte-times (2 with running status). No backpressure; downstream always accepts.

Test Plan:
- Bench setup for all scenarios: CLK_HZ=1_000_000, BAUD=31250, so CLKS_PER_BIT=32.
- Note on: omni=1; send 0x90 0x3C 0x64 -> one out_valid; on_off=1, note=0x3C, volume=0xC, channel=0. Edge count matches the latency rule.
- Running status and velocity-0 off: send 0x91 0x40 0x7F 0x40 0x00 -> two events: (on, 0x40, vol 0xF, ch 1) then (off, 0x40, vol 0x0, ch 1).
- Note off and realtime interleave: send 0x85 0x45 0xF8 0x20 -> one event: on_off=0, note=0x45, volume=0x4, channel=5. 0xF8 causes no state change.
- Channel filter: omni=0, channel_sel=2; send 0x93 0x30 0x40 then 0x92 0x30 0x40 -> exactly one event, channel=2, note=0x30.
- Framing error: send 0x90, then 0x3C with stop bit forced to 0, then 0x50 0x10 -> frame_err pulses once; no event (running status is cleared, so the stray data bytes are ignored).
- Glitch and reset: a 5-cycle low pulse on rx -> no byte. Assert reset during the velocity byte of 0x90 0x3C 0x64 -> all outputs 0, no event. Resend the full message -> normal event.
